// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war score keeper.
package tow_pkg;

    typedef enum logic [1:0] {PLAY, WON, MATCH} tow_state_t;

    function automatic int unsigned level_width(input int unsigned levels);
        return $clog2(levels + 1);
    endfunction

endpackage

// File: rtl/tow_therm.sv
// Level-to-thermometer encoder: level k lights the top k bits, MSB first.
module tow_therm
    import tow_pkg::*;
#(
    parameter int unsigned LEVELS = 4
) (
    input  logic [level_width(LEVELS)-1:0] level,
    output logic [LEVELS-1:0]              pattern
);

    localparam logic [LEVELS-1:0] ONES = '1;

    // Shifting ones out from the top leaves the unlit bits; level==LEVELS gives all ones.
    assign pattern = ~(ONES >> level);

endmodule

// File: rtl/tow_scoreboard.sv
// One player's bar position, round counting and match detection.
module tow_scoreboard
    import tow_pkg::*;
#(
    parameter int unsigned LEVELS        = 4,
    parameter int unsigned ROUNDS_TO_WIN = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     idle,
    input  logic                           increment,
    input  logic                           new_round,
    output logic [LEVELS-1:0]              pattern,
    output logic [level_width(LEVELS)-1:0] level,
    output logic                           vulnerable,
    output logic                           win,
    output logic                           round_win_pulse,
    output logic [3:0]                     rounds,
    output logic                           match_win
);

    localparam int unsigned   LW   = level_width(LEVELS);
    localparam logic [LW-1:0] TOP  = LW'(LEVELS);
    localparam logic [LW-1:0] ONE  = LW'(1);
    localparam logic [3:0]    GOAL = 4'(ROUNDS_TO_WIN);

    tow_state_t        state;
    logic [LEVELS-1:0] therm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= PLAY;
            level           <= '0;
            rounds          <= '0;
            round_win_pulse <= 1'b0;
        end else begin
            round_win_pulse <= 1'b0;
            case (state)
                PLAY: begin
                    if (idle == 2'b00) begin
                        if (increment) begin
                            if (level == TOP) begin
                                rounds          <= rounds + 4'd1;
                                round_win_pulse <= 1'b1;
                                state           <= (rounds + 4'd1 == GOAL) ? MATCH : WON;
                            end else begin
                                level <= level + ONE;
                            end
                        end else if (level != '0) begin
                            level <= level - ONE;
                        end
                    end
                end
                WON: begin
                    if (new_round) begin
                        level <= '0;
                        state <= PLAY;
                    end
                end
                MATCH: ;
                default: state <= PLAY;
            endcase
        end
    end

    tow_therm #(.LEVELS(LEVELS)) u_therm (
        .level   (level),
        .pattern (therm)
    );

    assign pattern    = win ? '1 : therm;
    assign vulnerable = (state == PLAY) && (level <= ONE);
    assign win        = (state != PLAY);
    assign match_win  = (state == MATCH);

endmodule

// File: tb/tb_tow_scoreboard.sv
// Directed bench for two configurations driven in lockstep, checked against a reference model.
module tb_tow_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] idle = 2'b00;
    logic       increment = 1'b0;
    logic       new_round = 1'b0;

    logic [3:0] a_pattern;
    logic [2:0] a_level;
    logic       a_vuln, a_win, a_pulse, a_match;
    logic [3:0] a_rounds;

    logic [7:0] b_pattern;
    logic [3:0] b_level;
    logic       b_vuln, b_win, b_pulse, b_match;
    logic [3:0] b_rounds;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tow_scoreboard #(.LEVELS(4), .ROUNDS_TO_WIN(2)) dut_a (
        .clk(clk), .reset(reset), .idle(idle), .increment(increment), .new_round(new_round),
        .pattern(a_pattern), .level(a_level), .vulnerable(a_vuln), .win(a_win),
        .round_win_pulse(a_pulse), .rounds(a_rounds), .match_win(a_match)
    );

    tow_scoreboard #(.LEVELS(8), .ROUNDS_TO_WIN(1)) dut_b (
        .clk(clk), .reset(reset), .idle(idle), .increment(increment), .new_round(new_round),
        .pattern(b_pattern), .level(b_level), .vulnerable(b_vuln), .win(b_win),
        .round_win_pulse(b_pulse), .rounds(b_rounds), .match_win(b_match)
    );

    // Reference model: phase 0 = playing, 1 = round won, 2 = match over.
    typedef struct {
        bit valid;
        int lvl;
        int rnds;
        int phase;
        bit pulse;
    } mdl_t;

    mdl_t ma = '{valid: 1'b0, lvl: 0, rnds: 0, phase: 0, pulse: 1'b0};
    mdl_t mb = '{valid: 1'b0, lvl: 0, rnds: 0, phase: 0, pulse: 1'b0};

    function automatic mdl_t step(input mdl_t m, input int top, input int goal,
                                  input bit rst, input logic [1:0] idl,
                                  input bit inc, input bit nr);
        mdl_t n = m;
        n.pulse = 1'b0;
        if (rst) begin
            n.valid = 1'b1; n.lvl = 0; n.rnds = 0; n.phase = 0;
        end else if (m.phase == 0 && idl == 2'b00) begin
            if (inc && m.lvl == top) begin
                n.rnds  = m.rnds + 1;
                n.pulse = 1'b1;
                n.phase = (n.rnds >= goal) ? 2 : 1;
            end else if (inc) begin
                n.lvl = m.lvl + 1;
            end else begin
                n.lvl = (m.lvl > 0) ? m.lvl - 1 : 0;
            end
        end else if (m.phase == 1 && nr) begin
            n.lvl = 0; n.phase = 0;
        end
        return n;
    endfunction

    function automatic int exp_pattern(input mdl_t m, input int top);
        if (m.phase != 0) return (1 << top) - 1;
        return ((1 << m.lvl) - 1) << (top - m.lvl);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma = step(ma, 4, 2, reset, idle, increment, new_round);
        mb = step(mb, 8, 1, reset, idle, increment, new_round);
    end

    always @(negedge clk) begin
        if (ma.valid) begin
            chk("A.pattern", 32'(a_pattern), 32'(exp_pattern(ma, 4)));
            chk("A.level",   32'(a_level),   32'(ma.lvl));
            chk("A.vuln",    32'(a_vuln),    32'(ma.phase == 0 && ma.lvl <= 1));
            chk("A.win",     32'(a_win),     32'(ma.phase != 0));
            chk("A.pulse",   32'(a_pulse),   32'(ma.pulse));
            chk("A.rounds",  32'(a_rounds),  32'(ma.rnds));
            chk("A.match",   32'(a_match),   32'(ma.phase == 2));
        end
        if (mb.valid) begin
            chk("B.pattern", 32'(b_pattern), 32'(exp_pattern(mb, 8)));
            chk("B.level",   32'(b_level),   32'(mb.lvl));
            chk("B.vuln",    32'(b_vuln),    32'(mb.phase == 0 && mb.lvl <= 1));
            chk("B.win",     32'(b_win),     32'(mb.phase != 0));
            chk("B.pulse",   32'(b_pulse),   32'(mb.pulse));
            chk("B.rounds",  32'(b_rounds),  32'(mb.rnds));
            chk("B.match",   32'(b_match),   32'(mb.phase == 2));
        end
    end

    // Drive one cycle's inputs, then return 1 time unit after the sampling edge.
    task automatic apply(input bit r, input logic [1:0] i, input bit inc, input bit nr);
        reset = r; idle = i; increment = inc; new_round = nr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".level"},   32'(a_level),   32'd0);
        chk({tag, ".pattern"}, 32'(a_pattern), 32'h0);
        chk({tag, ".vuln"},    32'(a_vuln),    32'd1);
        chk({tag, ".win"},     32'(a_win),     32'd0);
        chk({tag, ".pulse"},   32'(a_pulse),   32'd0);
        chk({tag, ".rounds"},  32'(a_rounds),  32'd0);
        chk({tag, ".match"},   32'(a_match),   32'd0);
    endtask

    logic [3:0] exp_pat4 [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic       exp_vul4 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        // Reset and climb to the top
        apply(1, 2'b00, 0, 0);
        chk_reset_a("rst0");
        for (int k = 0; k < 4; k++) begin
            apply(0, 2'b00, 1, 0);
            chk("climb.level",   32'(a_level),   32'(k + 1));
            chk("climb.pattern", 32'(a_pattern), 32'(exp_pat4[k]));
            chk("climb.vuln",    32'(a_vuln),    32'(exp_vul4[k]));
        end
        apply(0, 2'b00, 1, 0);
        chk("win1.win",    32'(a_win),    32'd1);
        chk("win1.pulse",  32'(a_pulse),  32'd1);
        chk("win1.rounds", 32'(a_rounds), 32'd1);
        chk("win1.level",  32'(a_level),  32'd4);
        apply(0, 2'b00, 0, 0);
        chk("won.pulse_drop", 32'(a_pulse), 32'd0);
        chk("won.level_held", 32'(a_level), 32'd4);

        // new_round beats a simultaneous increment
        apply(0, 2'b00, 1, 1);
        chk("nr.level",  32'(a_level),  32'd0);
        chk("nr.win",    32'(a_win),    32'd0);
        chk("nr.rounds", 32'(a_rounds), 32'd1);

        // Decay and floor at zero
        for (int k = 0; k < 3; k++) apply(0, 2'b00, 1, 0);
        chk("decay.start", 32'(a_level), 32'd3);
        apply(0, 2'b00, 0, 0);
        chk("decay.2", 32'(a_level), 32'd2);
        apply(0, 2'b00, 0, 0);
        chk("decay.1", 32'(a_level), 32'd1);
        for (int k = 0; k < 3; k++) apply(0, 2'b00, 0, 0);
        chk("decay.floor", 32'(a_level), 32'd0);

        // Idle freezes the bar
        apply(0, 2'b00, 1, 0);
        apply(0, 2'b00, 1, 0);
        for (int k = 0; k < 3; k++) apply(0, 2'b01, 1, 0);
        chk("idle.level",   32'(a_level),   32'd2);
        chk("idle.pattern", 32'(a_pattern), 32'hC);
        apply(0, 2'b10, 0, 0);
        chk("idle10.level", 32'(a_level), 32'd2);
        apply(0, 2'b00, 1, 0);
        chk("idle.release", 32'(a_level), 32'd3);
        apply(0, 2'b00, 1, 0);
        apply(0, 2'b01, 1, 0);
        chk("idle.blocks_win", 32'(a_win), 32'd0);

        // Second round win ends the match
        apply(0, 2'b00, 1, 0);
        chk("match.match",  32'(a_match),  32'd1);
        chk("match.rounds", 32'(a_rounds), 32'd2);
        chk("match.pulse",  32'(a_pulse),  32'd1);
        apply(0, 2'b00, 0, 1);
        for (int k = 0; k < 3; k++) apply(0, 2'b00, 1, 0);
        chk("match.sticky", 32'(a_match),  32'd1);
        chk("match.rounds_sat", 32'(a_rounds), 32'd2);
        chk("match.pattern", 32'(a_pattern), 32'hF);

        // Reset from MATCH and from mid-round
        apply(1, 2'b00, 1, 1);
        chk_reset_a("rst_match");
        for (int k = 0; k < 3; k++) apply(0, 2'b00, 1, 0);
        chk("pre_rst.level", 32'(a_level), 32'd3);
        apply(1, 2'b00, 1, 0);
        chk_reset_a("rst_play");

        // Wide bar, single round: first win goes straight to MATCH
        for (int k = 0; k < 8; k++) apply(0, 2'b00, 1, 0);
        chk("b8.level",   32'(b_level),   32'd8);
        chk("b8.pattern", 32'(b_pattern), 32'hFF);
        chk("b8.win",     32'(b_win),     32'd0);
        apply(0, 2'b00, 1, 0);
        chk("b9.match",   32'(b_match),   32'd1);
        chk("b9.win",     32'(b_win),     32'd1);
        chk("b9.rounds",  32'(b_rounds),  32'd1);
        chk("b9.pulse",   32'(b_pulse),   32'd1);
        chk("b9.pattern", 32'(b_pattern), 32'hFF);
        apply(0, 2'b00, 0, 0);
        chk("b10.pulse",  32'(b_pulse),   32'd0);
        apply(0, 2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tow_scoreboard.md
Name: tow_scoreboard

Overview:
- Parametrised successor to the tug-of-war score keeper.
- Tracks one player's bar position as a thermometer of LEVELS LEDs and detects a round win when the bar is pushed past the top.
- Counts round wins and declares a match win after ROUNDS_TO_WIN rounds.
- Sits between the press-arbitration logic (increment/idle) and the LED/HEX display drivers.

Parameters:
- LEVELS, 4, number of bar LEDs; legal range 2..16.
- ROUNDS_TO_WIN, 3, rounds needed for a match win; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- idle  in  2  hold request; either bit set freezes the bar for that cycle
- increment  in  1  player pressed this cycle; advance bar
- new_round  in  1  single-cycle pulse; restart bar after a round win
- pattern  out  LEVELS  thermometer, MSB-first, level k lights the top k bits
- level  out  $clog2(LEVELS+1)  current bar level, 0..LEVELS
- vulnerable  out  1  high when level <= 1 and state is PLAY
- win  out  1  high while state is WON or MATCH
- round_win_pulse  out  1  one-cycle pulse on entry to WON or MATCH
- rounds  out  4  round wins so far, saturating at ROUNDS_TO_WIN
- match_win  out  1  sticky; high in MATCH

Behaviour:
- Clocking and reset:
  - All outputs are registered or decoded from registers.
  - Effect of inputs is visible the cycle after the sampling edge.
  - Synchronous reset: state=PLAY, level=0, rounds=0, pattern=0, vulnerable=1, win=0, round_win_pulse=0, match_win=0.
  - Reset has priority over every other input, including mid-round and in MATCH.
- State PLAY:
  - If idle!=0: level holds and increment is ignored.
  - Else if increment: when level<LEVELS, level+1. When level==LEVELS, enter WON (or MATCH if rounds+1==ROUNDS_TO_WIN), rounds+1, pulse round_win_pulse, and level stays LEVELS.
  - Else (no increment): level-1, saturating at 0.
- State WON:
  - level frozen at LEVELS; increment and idle are ignored.
  - new_round=1: level=0, next state PLAY.
- State MATCH:
  - Terminal. new_round, increment and idle are ignored; only reset exits.
- Simultaneous events:
  - new_round in PLAY is ignored.
  - new_round and increment in the same WON cycle: new_round wins, and increment is not counted.
  - idle asserted on the top-level cycle blocks the win.
- Outputs:
  - pattern = thermometer(level); all ones while win is high.
  - rounds never exceeds ROUNDS_TO_WIN.
  - round_win_pulse is high for exactly one cycle per round won.

Decomposition:
- Package tow_pkg holds:
  - typedef enum logic [1:0] {PLAY, WON, MATCH} tow_state_t
  - function/constant for level width, $clog2(LEVELS+1)
- One sub-module, tow_therm: pure combinational level-to-thermometer encoder, parameter LEVELS. Reused by the HEX/LED display path.

Test Plan (LEVELS=4, ROUNDS_TO_WIN=2 unless noted):
1. Reset, then 4 increments with idle=0 -> level 1,2,3,4; pattern 1000,1100,1110,1111; vulnerable=1 only at levels 0,1. 5th increment -> win=1, round_win_pulse one cycle, rounds=1.
2. From level 3, two cycles with idle=0 and increment=0 -> level 2 then 1; three more -> level 0 and holds at 0 (no underflow).
3. idle=2'b01 for 3 cycles with increment=1 at level 2 -> level stays 2 and pattern 1100; idle=0 releases and counting resumes.
4. In WON, assert new_round and increment together -> next cycle level=0, state PLAY, rounds unchanged at 1. Win a second round -> match_win=1, rounds=2. new_round, then increments -> no change.
5. Assert reset while in MATCH and while at level 3 in PLAY -> all outputs at reset values the next cycle.
6. LEVELS=8, ROUNDS_TO_WIN=1 -> 9 increments give match_win=1 and pattern 8'hFF; the first win goes directly to MATCH.
